// File: rtl/score_tracker.sv
// score_tracker
// Owns the game score. Each frame (rising edge of the synchronised VGA vsync)
// at most one newly hit object is awarded: the lowest-index object whose hit
// flag is set and which has not yet been collected this level. A sequential
// double-dabble engine converts the binary score to BCD for the HEX/colour
// display path. The BCD output only ever changes as a whole, at the end of a
// conversion.
//
// Ports:
//   Clk        system/pixel clock, all state on the rising edge
//   Reset_n    asynchronous active-low reset
//   frame_vs   raw vsync level (asynchronous, synchronised internally)
//   hit        per-object collision flags, sampled on the frame tick
//   increment  points added per award
//   clear      synchronous level restart: zero score, re-arm all objects
//   score      binary score
//   collected  sticky per-object awarded flags
//   bcd        BCD score, digit 0 in [3:0]
//   bcd_valid  1 when bcd reflects the current score
//   overflow   an award went past MAX_SCORE
//
// Build option SCORE_SATURATE_EN: when defined the score saturates at
// MAX_SCORE and overflow is sticky until clear/reset. When undefined the
// score wraps modulo MAX_SCORE+1 and overflow is a one-cycle pulse.

module score_tracker #(
  parameter int NUM_OBJ    = 4,
  parameter int SCORE_W    = 10,
  parameter int NUM_DIGITS = 3,
  parameter int MAX_SCORE  = 999
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_vs,
  input  logic [NUM_OBJ-1:0]      hit,
  input  logic [SCORE_W-1:0]      increment,
  input  logic                    clear,
  output logic [SCORE_W-1:0]      score,
  output logic [NUM_OBJ-1:0]      collected,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    bcd_valid,
  output logic                    overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SH_W  = BCD_W + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  localparam logic [SCORE_W:0]   MAX_EXT  = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCORE_W - 1);
`ifndef SCORE_SATURATE_EN
  localparam logic [SCORE_W:0]   WRAP_EXT = (SCORE_W + 1)'(MAX_SCORE + 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } bcd_state_t;

  logic                 vs_meta;
  logic                 vs_sync;
  logic                 vs_prev;
  logic                 frame_tick;

  logic [NUM_OBJ-1:0]   cand;
  logic [NUM_OBJ-1:0]   award_mask;
  logic                 award_found;
  logic [SCORE_W:0]     sum;
  logic                 exceeds;
`ifndef SCORE_SATURATE_EN
  logic [SCORE_W-1:0]   wrapped;
`endif

  logic                 score_chg;

  bcd_state_t           state;
  logic [SH_W-1:0]      shreg;
  logic [SH_W-1:0]      shreg_next;
  logic [CNT_W-1:0]     cnt;
  logic                 pending;

  // Two flops bring vsync into the Clk domain, a third remembers the previous
  // synchronised level so a rising edge gives exactly one frame_tick cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= frame_vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_tick = vs_sync & ~vs_prev;

  // Pick the lowest-index object that is hit and not yet collected; any other
  // candidates stay uncollected and win on later frames.
  always_comb begin
    cand        = hit & ~collected;
    award_mask  = '0;
    award_found = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (cand[i] && !award_found) begin
        award_mask[i] = 1'b1;
        award_found   = 1'b1;
      end
    end
  end

  // The sum carries one extra bit so a past-the-limit result is never lost
  // before it is compared against MAX_SCORE.
  always_comb begin
    sum     = {1'b0, score} + {1'b0, increment};
    exceeds = (sum > MAX_EXT);
  end

`ifndef SCORE_SATURATE_EN
  assign wrapped = SCORE_W'(sum - WRAP_EXT);
`endif

  // Score, collected flags and overflow. clear beats a frame tick in the same
  // cycle, so a restart never also awards. score_chg tells the BCD engine a
  // new conversion is needed (even when the increment is zero).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score     <= '0;
      collected <= '0;
      overflow  <= 1'b0;
      score_chg <= 1'b0;
    end else if (clear) begin
      score     <= '0;
      collected <= '0;
      overflow  <= 1'b0;
      score_chg <= 1'b0;
    end else begin
      score_chg <= 1'b0;
`ifndef SCORE_SATURATE_EN
      overflow  <= 1'b0;
`endif
      if (frame_tick && award_found) begin
        collected <= collected | award_mask;
        score_chg <= 1'b1;
        if (exceeds) begin
`ifdef SCORE_SATURATE_EN
          score    <= MAX_VAL;
          overflow <= 1'b1;
`else
          score    <= wrapped;
          overflow <= 1'b1;
`endif
        end else begin
          score <= sum[SCORE_W-1:0];
        end
      end
    end
  end

  // One double-dabble step: every BCD digit of 5 or more gets 3 added, then
  // the whole register shifts left by one.
  always_comb begin
    shreg_next = shreg;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (shreg_next[SCORE_W + 4*d +: 4] >= 4'd5) begin
        shreg_next[SCORE_W + 4*d +: 4] = shreg_next[SCORE_W + 4*d +: 4] + 4'd3;
      end
    end
    shreg_next = shreg_next << 1;
  end

  // Conversion FSM. bcd is only written in DONE so the display never sees a
  // half-converted value. A score change arriving while a conversion is in
  // flight sets pending, and DONE then restarts from LOAD instead of
  // reporting the now-stale result as valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
      pending   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      bcd       <= '0;
      bcd_valid <= 1'b1;
      pending   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (score_chg) begin
            state     <= LOAD;
            bcd_valid <= 1'b0;
          end
        end
        LOAD: begin
          shreg <= {{BCD_W{1'b0}}, score};
          cnt   <= '0;
          state <= SHIFT;
          if (score_chg) pending <= 1'b1;
        end
        SHIFT: begin
          shreg <= shreg_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= DONE;
          if (score_chg) pending <= 1'b1;
        end
        DONE: begin
          bcd <= shreg[SH_W-1 -: BCD_W];
          if (pending || score_chg) begin
            state     <= LOAD;
            pending   <= 1'b0;
            bcd_valid <= 1'b0;
          end else begin
            state     <= IDLE;
            bcd_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker
// Randomised and directed stimulus for score_tracker, checked against a
// frame-level reference model: one award per frame, lowest uncollected index,
// plain integer add with wrap or saturation, BCD digits by divide/modulo.

module tb_score_tracker;

  localparam int NUM_OBJ    = 4;
  localparam int SCORE_W    = 10;
  localparam int NUM_DIGITS = 3;
  localparam int MAX_SCORE  = 999;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_vs;
  logic [3:0]  hit;
  logic [9:0]  increment;
  logic        clear;
  logic [9:0]  score;
  logic [3:0]  collected;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        overflow;

  int checks = 0;
  int passed = 0;

  // reference model state
  int         m_score;
  logic [3:0] m_coll;
  logic       m_ovf;
  int         m_pulses;

  // monitors
  int         ovf_cycles = 0;
  int         stale_err  = 0;
  logic [9:0] prev_score = '0;

  score_tracker #(
    .NUM_OBJ(NUM_OBJ),
    .SCORE_W(SCORE_W),
    .NUM_DIGITS(NUM_DIGITS),
    .MAX_SCORE(MAX_SCORE)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_vs(frame_vs),
    .hit(hit),
    .increment(increment),
    .clear(clear),
    .score(score),
    .collected(collected),
    .bcd(bcd),
    .bcd_valid(bcd_valid),
    .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Count overflow-high cycles, and flag any cycle where bcd is marked valid
  // but disagrees with a score that has been stable for at least one cycle.
  always @(negedge Clk) begin
    if (overflow === 1'b1) ovf_cycles++;
    if (bcd_valid === 1'b1 && bcd !== to_bcd(int'(score)) && score === prev_score)
      stale_err++;
    prev_score = score;
  end

  function automatic void model_clear();
    m_score = 0;
    m_coll  = '0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_frame(input logic [3:0] h, input logic [9:0] inc);
    logic [3:0] c;
    int         sum;
    bit         done;
    c    = h & ~m_coll;
    done = 0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      if (c[k] && !done) begin
        done      = 1;
        m_coll[k] = 1'b1;
        sum       = m_score + int'(inc);
        if (sum > MAX_SCORE) begin
`ifdef SCORE_SATURATE_EN
          m_score = MAX_SCORE;
          m_ovf   = 1'b1;
`else
          m_score = sum - (MAX_SCORE + 1);
          m_pulses++;
`endif
        end else begin
          m_score = sum;
        end
      end
    end
  endfunction

  // One ordinary-length frame with hit/increment held throughout.
  task automatic applyStimulus(input logic [3:0] h, input logic [9:0] inc);
    @(negedge Clk);
    hit       = h;
    increment = inc;
    frame_vs  = 1'b1;
    repeat (4) @(negedge Clk);
    frame_vs  = 1'b0;
    repeat (3) @(negedge Clk);
    model_frame(h, inc);
  endtask

  task automatic do_clear();
    @(negedge Clk);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic wait_conv(output bit ok);
    int n = 0;
    while (bcd_valid !== 1'b1 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    ok = (bcd_valid === 1'b1);
  endtask

  task automatic test_reset();
    Reset_n   = 1'b0;
    frame_vs  = 1'b0;
    hit       = '0;
    increment = '0;
    clear     = 1'b0;
    model_clear();
    m_pulses  = 0;
    repeat (3) @(negedge Clk);
    checks++; if (score !== 10'd0) $display("[TB] FAIL reset_score: got %0d expected 0", score); else passed++;
    checks++; if (collected !== 4'd0) $display("[TB] FAIL reset_collected: got %b expected 0000", collected); else passed++;
    checks++; if (bcd !== 12'h000) $display("[TB] FAIL reset_bcd: got %h expected 000", bcd); else passed++;
    checks++; if (bcd_valid !== 1'b1) $display("[TB] FAIL reset_bcd_valid: got %b expected 1", bcd_valid); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else passed++;
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_single_coin();
    logic [9:0] old;
    int  n;
    int  lat;
    bit  dropped;
    bit  ok;
    do_clear();
    @(negedge Clk);
    old       = score;
    hit       = 4'b0001;
    increment = 10'd1;
    frame_vs  = 1'b1;
    n = 0;
    while (score === old && n < 10) begin
      @(negedge Clk);
      n++;
    end
    lat = 0;
    dropped = 0;
    while (bcd_valid !== 1'b1 || lat == 0) begin
      @(negedge Clk);
      lat++;
      if (lat == 1) dropped = (bcd_valid === 1'b0);
      if (lat >= 40) break;
    end
    frame_vs = 1'b0;
    model_frame(4'b0001, 10'd1);
    checks++; if (lat != 13) $display("[TB] FAIL coin_latency: got %0d cycles expected 13", lat); else passed++;
    checks++; if (!dropped) $display("[TB] FAIL coin_valid_drop: bcd_valid not low the cycle after score change"); else passed++;
    checks++; if (bcd !== to_bcd(m_score)) $display("[TB] FAIL coin_bcd: got %h expected %h", bcd, to_bcd(m_score)); else passed++;
    applyStimulus(4'b0001, 10'd1);
    applyStimulus(4'b0001, 10'd1);
    wait_conv(ok);
    checks++; if (!ok) $display("[TB] FAIL coin_conv_timeout: bcd_valid stuck at %b", bcd_valid); else passed++;
    checks++; if (score !== 10'(m_score)) $display("[TB] FAIL coin_score: got %0d expected %0d", score, m_score); else passed++;
    checks++; if (collected !== m_coll) $display("[TB] FAIL coin_collected: got %b expected %b", collected, m_coll); else passed++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_clear();
    applyStimulus(4'b1010, 10'd5);
    checks++; if (score !== 10'(m_score)) $display("[TB] FAIL sim_f1_score: got %0d expected %0d", score, m_score); else passed++;
    checks++; if (collected !== m_coll) $display("[TB] FAIL sim_f1_collected: got %b expected %b", collected, m_coll); else passed++;
    applyStimulus(4'b1010, 10'd5);
    wait_conv(ok);
    checks++; if (!ok) $display("[TB] FAIL sim_conv_timeout: bcd_valid stuck at %b", bcd_valid); else passed++;
    checks++; if (score !== 10'(m_score)) $display("[TB] FAIL sim_f2_score: got %0d expected %0d", score, m_score); else passed++;
    checks++; if (collected !== m_coll) $display("[TB] FAIL sim_f2_collected: got %b expected %b", collected, m_coll); else passed++;
    checks++; if (bcd !== to_bcd(m_score)) $display("[TB] FAIL sim_bcd: got %h expected %h", bcd, to_bcd(m_score)); else passed++;
  endtask

  task automatic test_clear_race();
    bit ok;
    applyStimulus(4'b0100, 10'd7);
    wait_conv(ok);
    @(negedge Clk);
    hit       = 4'b0001;
    increment = 10'd9;
    frame_vs  = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    model_clear();
    checks++; if (score !== 10'd0) $display("[TB] FAIL race_score: got %0d expected 0", score); else passed++;
    checks++; if (collected !== 4'd0) $display("[TB] FAIL race_collected: got %b expected 0000", collected); else passed++;
    checks++; if (bcd !== 12'h000 || bcd_valid !== 1'b1) $display("[TB] FAIL race_bcd: got %h/%b expected 000/1", bcd, bcd_valid); else passed++;
    repeat (20) @(negedge Clk);
    frame_vs = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (score !== 10'd0 || collected !== 4'd0) $display("[TB] FAIL race_no_award: got %0d/%b expected 0/0000", score, collected); else passed++;
  endtask

  task automatic test_overflow();
    bit ok;
    do_clear();
    applyStimulus(4'b0001, 10'd499);
    applyStimulus(4'b0010, 10'd499);
    wait_conv(ok);
    checks++; if (score !== 10'd998) $display("[TB] FAIL ovf_pre_score: got %0d expected 998", score); else passed++;
    applyStimulus(4'b0100, 10'd5);
    wait_conv(ok);
    repeat (2) @(negedge Clk);
    checks++; if (!ok) $display("[TB] FAIL ovf_conv_timeout: bcd_valid stuck at %b", bcd_valid); else passed++;
    checks++; if (score !== 10'(m_score)) $display("[TB] FAIL ovf_score: got %0d expected %0d", score, m_score); else passed++;
    checks++; if (bcd !== to_bcd(m_score)) $display("[TB] FAIL ovf_bcd: got %h expected %h", bcd, to_bcd(m_score)); else passed++;
`ifdef SCORE_SATURATE_EN
    checks++; if (overflow !== m_ovf) $display("[TB] FAIL ovf_flag: got %b expected %b", overflow, m_ovf); else passed++;
`else
    checks++; if (ovf_cycles != m_pulses) $display("[TB] FAIL ovf_pulses: got %0d expected %0d", ovf_cycles, m_pulses); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_pulse_end: got %b expected 0", overflow); else passed++;
`endif
  endtask

  task automatic test_pending();
    int         base;
    bit         ok;
    logic [9:0] inc;
    do_clear();
    base = stale_err;
    hit  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      inc = 10'($urandom_range(1, 200));
      @(negedge Clk);
      increment = inc;
      frame_vs  = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      frame_vs  = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      model_frame(4'b1111, inc);
    end
    wait_conv(ok);
    checks++; if (!ok) $display("[TB] FAIL pend_conv_timeout: bcd_valid stuck at %b", bcd_valid); else passed++;
    checks++; if (score !== 10'(m_score)) $display("[TB] FAIL pend_score: got %0d expected %0d", score, m_score); else passed++;
    checks++; if (collected !== m_coll) $display("[TB] FAIL pend_collected: got %b expected %b", collected, m_coll); else passed++;
    checks++; if (bcd !== to_bcd(m_score)) $display("[TB] FAIL pend_bcd: got %h expected %h", bcd, to_bcd(m_score)); else passed++;
    checks++; if (stale_err != base) $display("[TB] FAIL pend_stale: got %0d stale-valid cycles expected 0", stale_err - base); else passed++;
  endtask

  task automatic test_random();
    bit         ok;
    logic [3:0] h;
    logic [9:0] inc;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) do_clear();
      h   = 4'($urandom_range(0, 15));
      inc = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 350));
      applyStimulus(h, inc);
      wait_conv(ok);
      checks++; if (!ok) $display("[TB] FAIL rnd%0d_conv_timeout: bcd_valid stuck at %b", i, bcd_valid); else passed++;
      checks++; if (score !== 10'(m_score)) $display("[TB] FAIL rnd%0d_score: got %0d expected %0d", i, score, m_score); else passed++;
      checks++; if (collected !== m_coll) $display("[TB] FAIL rnd%0d_collected: got %b expected %b", i, collected, m_coll); else passed++;
      checks++; if (bcd !== to_bcd(m_score)) $display("[TB] FAIL rnd%0d_bcd: got %h expected %h", i, bcd, to_bcd(m_score)); else passed++;
`ifdef SCORE_SATURATE_EN
      checks++; if (overflow !== m_ovf) $display("[TB] FAIL rnd%0d_overflow: got %b expected %b", i, overflow, m_ovf); else passed++;
`else
      checks++; if (ovf_cycles != m_pulses) $display("[TB] FAIL rnd%0d_ovf_pulses: got %0d expected %0d", i, ovf_cycles, m_pulses); else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid_shift();
    do_clear();
    applyStimulus(4'b0011, 10'd123);
    repeat (3) @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (score !== 10'd0) $display("[TB] FAIL midrst_score: got %0d expected 0", score); else passed++;
    checks++; if (collected !== 4'd0) $display("[TB] FAIL midrst_collected: got %b expected 0000", collected); else passed++;
    checks++; if (bcd !== 12'h000 || bcd_valid !== 1'b1) $display("[TB] FAIL midrst_bcd: got %h/%b expected 000/1", bcd, bcd_valid); else passed++;
    model_clear();
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_simultaneous();
    test_clear_race();
    test_overflow();
    test_pending();
    test_random();
    test_reset_mid_shift();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
